// File: rtl/qspi_rshift.sv
// QSPI quad-lane receive shifter: samples one nibble per clock, assembles a 4..40 bit word
// and presents it right-justified with a one-cycle valid strobe and a sticky interrupt.
//   state | meaning
//   IDLE  | waiting for start_i with busy_i; rejects illegal sizes via err_o
//   SHIFT | sampling one nibble of sdi_i per cycle while busy_i is high
//   DONE  | one-cycle completion: valid strobe, interrupt set, bit index cleared
module qspi_rshift (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        busy_i,
    input  logic        start_i,
    input  logic        lsb_i,
    input  logic        msb_i,
    input  logic [5:0]  rsize_i,
    input  logic [3:0]  sdi_i,
    input  logic        intr_clr_i,
    output logic [39:0] dout_o,
    output logic        dout_valid_o,
    output logic [5:0]  bit_index_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        r_intr_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [39:0] sr_q, sr_d, dout_d;
    logic [5:0]  size_q, size_d, idx_d, eff_size;
    logic        lsb_q, lsb_d, err_d, intr_d;
    logic        size_ok, last_nib;

    always_comb begin
        eff_size = {rsize_i[5:2], 2'b00};
        size_ok  = (eff_size != 6'd0) && (eff_size <= 6'd40);
        last_nib = (bit_index_o == size_q - 6'd4);
        state_d  = state_q;
        sr_d     = sr_q;
        size_d   = size_q;
        lsb_d    = lsb_q;
        idx_d    = bit_index_o;
        dout_d   = dout_o;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && busy_i) begin
                    if (!size_ok) begin
                        err_d = 1'b1;
                    end else begin
                        size_d  = eff_size;
                        lsb_d   = lsb_i | ~msb_i;
                        sr_d    = '0;
                        idx_d   = 6'd0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (!busy_i) begin
                    state_d = IDLE;
                    idx_d   = 6'd0;
                    sr_d    = '0;
                end else begin
                    if (lsb_q) begin
                        for (int i = 0; i < 10; i++) begin
                            if (bit_index_o == 6'(4 * i)) sr_d[4*i +: 4] = sdi_i;
                        end
                    end else begin
                        sr_d = {sr_q[35:0], sdi_i};
                    end
                    idx_d = bit_index_o + 6'd4;
                    // Capture the word together with its final nibble so dout_o is
                    // already current while the valid strobe is high.
                    if (last_nib) begin
                        state_d = DONE;
                        for (int b = 0; b < 40; b++) begin
                            dout_d[b] = sr_d[b] & (b < int'(size_q));
                        end
                    end
                end
            end
            DONE: begin
                idx_d   = 6'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        intr_d = (state_q == DONE) | (r_intr_o & ~intr_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            size_q      <= '0;
            lsb_q       <= 1'b0;
            bit_index_o <= '0;
            dout_o      <= '0;
            err_o       <= 1'b0;
            r_intr_o    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            size_q      <= size_d;
            lsb_q       <= lsb_d;
            bit_index_o <= idx_d;
            dout_o      <= dout_d;
            err_o       <= err_d;
            r_intr_o    <= intr_d;
        end
    end

    assign dout_valid_o = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_rshift.sv
// Directed self-checking bench for qspi_rshift with hand-computed expected words.
module tb_qspi_rshift;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        busy_i, start_i, lsb_i, msb_i, intr_clr_i;
    logic [5:0]  rsize_i;
    logic [3:0]  sdi_i;
    logic [39:0] dout_o;
    logic        dout_valid_o, busy_o, err_o, r_intr_o;
    logic [5:0]  bit_index_o;

    int checks   = 0;
    int failures = 0;

    qspi_rshift dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .busy_i(busy_i), .start_i(start_i),
        .lsb_i(lsb_i), .msb_i(msb_i), .rsize_i(rsize_i), .sdi_i(sdi_i),
        .intr_clr_i(intr_clr_i), .dout_o(dout_o), .dout_valid_o(dout_valid_o),
        .bit_index_o(bit_index_o), .busy_o(busy_o), .err_o(err_o), .r_intr_o(r_intr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issues a start, feeds n nibbles and leaves the DUT in its DONE cycle.
    task automatic run_rx(input string tag, input logic l, input logic m, input logic [5:0] rs,
                          input logic [39:0] nib, input int n, input logic [39:0] exp);
        busy_i = 1'b1; lsb_i = l; msb_i = m; rsize_i = rs; start_i = 1'b1;
        step();
        chk({tag, "_busy_rise"}, 64'(busy_o), 64'd1);
        chk({tag, "_idx_first"}, 64'(bit_index_o), 64'd0);
        start_i = 1'b0;
        lsb_i = ~l; msb_i = ~m; rsize_i = 6'd0;
        for (int i = 0; i < n; i++) begin
            sdi_i = nib[4*i +: 4];
            if (i == n - 1) chk({tag, "_idx_last"}, 64'(bit_index_o), 64'(4 * (n - 1)));
            step();
            if (i < n - 1) chk({tag, "_no_early_valid"}, 64'(dout_valid_o), 64'd0);
        end
        chk({tag, "_valid"}, 64'(dout_valid_o), 64'd1);
        chk({tag, "_dout"}, 64'(dout_o), 64'(exp));
        sdi_i = 4'h0;
    endtask

    initial begin
        rst_ni = 1'b0; busy_i = 1'b0; start_i = 1'b0; lsb_i = 1'b0; msb_i = 1'b0;
        intr_clr_i = 1'b0; rsize_i = 6'd0; sdi_i = 4'h0;
        #12;
        chk("rst_dout", 64'(dout_o), 64'd0);
        chk("rst_outs", 64'({dout_valid_o, busy_o, err_o, r_intr_o}), 64'd0);
        chk("rst_idx", 64'(bit_index_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // LSB-first 8 bits
        run_rx("lsb8", 1'b1, 1'b0, 6'd8, 40'hA5, 2, 40'h00000000A5);
        step();
        chk("lsb8_valid_fall", 64'(dout_valid_o), 64'd0);
        chk("lsb8_busy_fall", 64'(busy_o), 64'd0);
        chk("lsb8_intr", 64'(r_intr_o), 64'd1);
        chk("lsb8_idx_zero", 64'(bit_index_o), 64'd0);
        chk("lsb8_dout_held", 64'(dout_o), 64'hA5);

        // MSB-first 8 bits, same nibble stream 0x5 then 0xA
        run_rx("msb8", 1'b0, 1'b1, 6'd8, 40'hA5, 2, 40'h000000005A);
        step();

        // Full 40 bits LSB-first, then with both selects high
        run_rx("lsb40", 1'b1, 1'b0, 6'd40, 40'h9876543210, 10, 40'h9876543210);
        step();
        run_rx("both40", 1'b1, 1'b1, 6'd40, 40'h9876543210, 10, 40'h9876543210);
        step();

        // Abort after two nibbles of a 16-bit receive, with interrupt cleared first
        intr_clr_i = 1'b1;
        step();
        intr_clr_i = 1'b0;
        chk("clr_intr", 64'(r_intr_o), 64'd0);
        busy_i = 1'b1; lsb_i = 1'b1; msb_i = 1'b0; rsize_i = 6'd16; start_i = 1'b1;
        step();
        start_i = 1'b0;
        sdi_i = 4'h1; step();
        sdi_i = 4'h2; step();
        busy_i = 1'b0; sdi_i = 4'h3;
        step();
        chk("abort_valid", 64'(dout_valid_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_idx", 64'(bit_index_o), 64'd0);
        chk("abort_dout", 64'(dout_o), 64'h9876543210);
        chk("abort_intr", 64'(r_intr_o), 64'd0);
        busy_i = 1'b1;
        step();
        chk("abort_stays_idle", 64'({busy_o, dout_valid_o}), 64'd0);

        // Illegal sizes
        rsize_i = 6'd44; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("err44_pulse", 64'(err_o), 64'd1);
        chk("err44_idle", 64'(busy_o), 64'd0);
        step();
        chk("err44_fall", 64'(err_o), 64'd0);
        rsize_i = 6'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("err0_pulse", 64'(err_o), 64'd1);
        chk("err0_idle", 64'(busy_o), 64'd0);
        step();

        // Size 10 behaves as 8
        run_rx("size10", 1'b1, 1'b0, 6'd10, 40'hC3, 2, 40'h00000000C3);
        chk("size10_err", 64'(err_o), 64'd0);

        // Clear coincident with DONE: set wins; start during DONE is ignored
        intr_clr_i = 1'b1; start_i = 1'b1; rsize_i = 6'd8; lsb_i = 1'b1; msb_i = 1'b0;
        step();
        chk("race_intr_set", 64'(r_intr_o), 64'd1);
        chk("done_start_ignored", 64'(busy_o), 64'd0);
        chk("done_start_no_err", 64'(err_o), 64'd0);
        step();
        intr_clr_i = 1'b0;
        chk("late_clr", 64'(r_intr_o), 64'd0);
        chk("restart_accepted", 64'(busy_o), 64'd1);
        start_i = 1'b0;
        sdi_i = 4'hE; step();
        sdi_i = 4'h7; step();
        chk("restart_valid", 64'(dout_valid_o), 64'd1);
        chk("restart_dout", 64'(dout_o), 64'h7E);
        step();

        // Asynchronous reset mid-SHIFT
        busy_i = 1'b1; rsize_i = 6'd16; start_i = 1'b1;
        step();
        start_i = 1'b0; sdi_i = 4'hF;
        step();
        rst_ni = 1'b0;
        #1;
        chk("arst_dout", 64'(dout_o), 64'd0);
        chk("arst_outs", 64'({dout_valid_o, busy_o, err_o, r_intr_o}), 64'd0);
        chk("arst_idx", 64'(bit_index_o), 64'd0);
        rst_ni = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
